// File: rtl/sync_generator_param.sv
// Parametrised raster timing generator: hsync/vsync, blank/de, pixel
// coordinates and line/frame start strobes for any standard video mode.
// Optional pixel clock-enable input is built when SYNC_GEN_PIXEL_CE_EN is defined.
module sync_generator_param #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BP      = 88,
  parameter int unsigned V_ACTIVE  = 600,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BP      = 23,
  parameter bit          HSYNC_POL = 1'b1,
  parameter bit          VSYNC_POL = 1'b1,
  parameter int unsigned CW        = 12
) (
  input  logic          clk,
  input  logic          reset,
`ifdef SYNC_GEN_PIXEL_CE_EN
  input  logic          ce,
`endif
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          de,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic          adv;
  logic [CW-1:0] hc_nxt;
  logic [CW-1:0] vc_nxt;
  logic [31:0]   hx;
  logic [31:0]   vx;
  logic          hs_act;
  logic          vs_act;
  logic          blank_nxt;

`ifdef SYNC_GEN_PIXEL_CE_EN
  assign adv = ce;
`else
  assign adv = 1'b1;
`endif

  // Position the counters will show after the next edge.
  always_comb begin
    hc_nxt = hc;
    vc_nxt = vc;
    if (adv) begin
      if (hc == CW'(H_TOTAL - 1)) begin
        hc_nxt = '0;
        if (vc == CW'(V_TOTAL - 1)) begin
          vc_nxt = '0;
        end else begin
          vc_nxt = vc + CW'(1);
        end
      end else begin
        hc_nxt = hc + CW'(1);
      end
    end
  end

  // Decode the upcoming position so every registered output lines up with hc/vc.
  always_comb begin
    hx        = 32'(hc_nxt);
    vx        = 32'(vc_nxt);
    hs_act    = (hx >= H_SYNC_START) && (hx < H_SYNC_END);
    vs_act    = (vx >= V_SYNC_START) && (vx < V_SYNC_END);
    blank_nxt = (hx >= H_ACTIVE) || (vx >= V_ACTIVE);
  end

  // Position and decoded timing registers; reset loads the (0,0) state.
  always_ff @(posedge clk) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      blank       <= 1'b0;
      de          <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      hsync       <= HSYNC_POL ? hs_act : ~hs_act;
      vsync       <= VSYNC_POL ? vs_act : ~vs_act;
      blank       <= blank_nxt;
      de          <= ~blank_nxt;
      // Strobes last a single clk cycle even when ce stalls on position 0.
      line_start  <= adv && (hc_nxt == '0);
      frame_start <= adv && (hc_nxt == '0) && (vc_nxt == '0);
    end
  end

endmodule

// File: tb/tb_sync_generator_param.sv
// Bench for sync_generator_param: three parameterisations (default 800x600,
// 640x480 negative polarity, and a tiny mode with 1-wide syncs and 0 porches).
module tb_sync_generator_param;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp;
    bit hp, vp;
  } cfg_t;

  typedef struct {
    int hc, vc;
    bit hs, vs, bl, de, ls, fs;
  } obs_t;

  typedef struct {
    bit   rst;
    obs_t e;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b1;

  logic        d0_hs, d0_vs, d0_bl, d0_de, d0_ls, d0_fs;
  logic [11:0] d0_hc, d0_vc;
  logic        d1_hs, d1_vs, d1_bl, d1_de, d1_ls, d1_fs;
  logic [11:0] d1_hc, d1_vc;
  logic        d2_hs, d2_vs, d2_bl, d2_de, d2_ls, d2_fs;
  logic [3:0]  d2_hc, d2_vc;

  always #5 clk = ~clk;

  sync_generator_param dut0 (
    .clk(clk), .reset(reset),
`ifdef SYNC_GEN_PIXEL_CE_EN
    .ce(ce),
`endif
    .hsync(d0_hs), .vsync(d0_vs), .blank(d0_bl), .de(d0_de),
    .hc(d0_hc), .vc(d0_vc), .line_start(d0_ls), .frame_start(d0_fs));

  sync_generator_param #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(12)
  ) dut1 (
    .clk(clk), .reset(reset),
`ifdef SYNC_GEN_PIXEL_CE_EN
    .ce(ce),
`endif
    .hsync(d1_hs), .vsync(d1_vs), .blank(d1_bl), .de(d1_de),
    .hc(d1_hc), .vc(d1_vc), .line_start(d1_ls), .frame_start(d1_fs));

  sync_generator_param #(
    .H_ACTIVE(8), .H_FP(0), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(4), .V_FP(0), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(4)
  ) dut2 (
    .clk(clk), .reset(reset),
`ifdef SYNC_GEN_PIXEL_CE_EN
    .ce(ce),
`endif
    .hsync(d2_hs), .vsync(d2_vs), .blank(d2_bl), .de(d2_de),
    .hc(d2_hc), .vc(d2_vc), .line_start(d2_ls), .frame_start(d2_fs));

  cfg_t cfg [3];
  int   mh [3];
  int   mv [3];
  obs_t q0 [$];
  obs_t q1 [$];
  obs_t q2 [$];

  int n_pass = 0;
  int n_total = 0;

  // Independent timing model built straight from the mode definition.
  function automatic obs_t decode(cfg_t c, int h, int v);
    obs_t o;
    bit hs_on, vs_on;
    hs_on = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs);
    vs_on = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs);
    o.hc = h;
    o.vc = v;
    o.hs = c.hp ? hs_on : !hs_on;
    o.vs = c.vp ? vs_on : !vs_on;
    o.bl = (h >= c.ha) || (v >= c.va);
    o.de = !o.bl;
    o.ls = (h == 0);
    o.fs = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic int htot(cfg_t c);
    return c.ha + c.hfp + c.hs + c.hbp;
  endfunction

  function automatic int vtot(cfg_t c);
    return c.va + c.vfp + c.vs + c.vbp;
  endfunction

  function automatic int next_h(cfg_t c, int h);
    return (h == htot(c) - 1) ? 0 : h + 1;
  endfunction

  function automatic int next_v(cfg_t c, int h, int v);
    if (h != htot(c) - 1) return v;
    return (v == vtot(c) - 1) ? 0 : v + 1;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_obs(string name, obs_t a, obs_t e);
    n_total++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got hc=%0d vc=%0d hs=%0b vs=%0b bl=%0b de=%0b ls=%0b fs=%0b, expected hc=%0d vc=%0d hs=%0b vs=%0b bl=%0b de=%0b ls=%0b fs=%0b",
                  name, a.hc, a.vc, a.hs, a.vs, a.bl, a.de, a.ls, a.fs,
                  e.hc, e.vc, e.hs, e.vs, e.bl, e.de, e.ls, e.fs);
  endtask

  function automatic obs_t mk(int h, int v, bit hs, bit vs, bit bl, bit ls, bit fs);
    obs_t o;
    o.hc = h; o.vc = v; o.hs = hs; o.vs = vs; o.bl = bl; o.de = !bl; o.ls = ls; o.fs = fs;
    return o;
  endfunction

  initial begin
    cfg[0] = '{ha: 800, hfp: 40, hs: 128, hbp: 88, va: 600, vfp: 1, vs: 4, vbp: 23, hp: 1'b1, vp: 1'b1};
    cfg[1] = '{ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 10, vs: 2, vbp: 33, hp: 1'b0, vp: 1'b0};
    cfg[2] = '{ha: 8, hfp: 0, hs: 1, hbp: 2, va: 4, vfp: 0, vs: 1, vbp: 1, hp: 1'b0, vp: 1'b0};
    for (int i = 0; i < 3; i++) begin
      mh[i] = 0;
      mv[i] = 0;
    end
  end

  // Scoreboard producer: advance the model on each edge and queue what each DUT must show.
  always @(posedge clk) begin
    if (reset) begin
      q0.push_back(decode(cfg[0], 0, 0));
      q1.push_back(decode(cfg[1], 0, 0));
      q2.push_back(decode(cfg[2], 0, 0));
      for (int i = 0; i < 3; i++) begin
        mh[i] <= 0;
        mv[i] <= 0;
      end
    end else begin
      q0.push_back(decode(cfg[0], next_h(cfg[0], mh[0]), next_v(cfg[0], mh[0], mv[0])));
      q1.push_back(decode(cfg[1], next_h(cfg[1], mh[1]), next_v(cfg[1], mh[1], mv[1])));
      q2.push_back(decode(cfg[2], next_h(cfg[2], mh[2]), next_v(cfg[2], mh[2], mv[2])));
      for (int i = 0; i < 3; i++) begin
        mh[i] <= next_h(cfg[i], mh[i]);
        mv[i] <= next_v(cfg[i], mh[i], mv[i]);
      end
    end
  end

  bit phase = 1'b0;
  int cyc = 0;
  int hs0_cnt = 0, hs0_first = -1, bl0_cnt = 0;
  int hs1_cnt = 0, hs1_first = -1;
  int ls0_n = 0, ls0_t0 = 0, ls0_t1 = 0;
  int fs2_n = 0, fs2_t0 = 0, fs2_t1 = 0, vs2_cnt = 0;

  // Scoreboard consumer plus explicit row/frame measurements, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (q0.size() > 0)
      chk_obs("dut0_cycle", mk(int'(d0_hc), int'(d0_vc), d0_hs, d0_vs, d0_bl, d0_ls, d0_fs), q0.pop_front());
    if (q1.size() > 0)
      chk_obs("dut1_cycle", mk(int'(d1_hc), int'(d1_vc), d1_hs, d1_vs, d1_bl, d1_ls, d1_fs), q1.pop_front());
    if (q2.size() > 0)
      chk_obs("dut2_cycle", mk(int'(d2_hc), int'(d2_vc), d2_hs, d2_vs, d2_bl, d2_ls, d2_fs), q2.pop_front());
    if (d0_de == d0_bl) chk("dut0_de_not_blank", int'(d0_de), int'(!d0_bl));
    if (phase) begin
      if (d0_vc == 12'd0) begin
        if (d0_hs) begin
          hs0_cnt++;
          if (hs0_first < 0) hs0_first = int'(d0_hc);
        end
        if (d0_bl) bl0_cnt++;
      end
      if (d1_vc == 12'd0 && !d1_hs) begin
        hs1_cnt++;
        if (hs1_first < 0) hs1_first = int'(d1_hc);
      end
      if (d0_ls) begin
        if (ls0_n == 0) ls0_t0 = cyc;
        else if (ls0_n == 1) ls0_t1 = cyc;
        ls0_n++;
      end
      if (d2_fs) begin
        if (fs2_n == 0) fs2_t0 = cyc;
        else if (fs2_n == 1) fs2_t1 = cyc;
        fs2_n++;
      end
      if (fs2_n == 1 && !d2_vs) vs2_cnt++;
    end
  end

  vec_t vt [$];

  initial begin
    vec_t v;
    bit found;

    // Tiny mode after a mid-frame reset: inactive syncs are high (negative polarity).
    v.rst = 1'b1; v.e = mk(0, 0, 1, 1, 0, 1, 1); vt.push_back(v);
    for (int h = 1; h <= 7; h++) begin
      v.rst = 1'b0; v.e = mk(h, 0, 1, 1, 0, 0, 0); vt.push_back(v);
    end
    v.rst = 1'b0; v.e = mk(8, 0, 0, 1, 1, 0, 0); vt.push_back(v);
    v.rst = 1'b0; v.e = mk(9, 0, 1, 1, 1, 0, 0); vt.push_back(v);
    v.rst = 1'b0; v.e = mk(10, 0, 1, 1, 1, 0, 0); vt.push_back(v);
    v.rst = 1'b0; v.e = mk(0, 1, 1, 1, 0, 1, 0); vt.push_back(v);
    v.rst = 1'b0; v.e = mk(1, 1, 1, 1, 0, 0, 0); vt.push_back(v);
    v.rst = 1'b1; v.e = mk(0, 0, 1, 1, 0, 1, 1); vt.push_back(v);
    v.rst = 1'b0; v.e = mk(1, 0, 1, 1, 0, 0, 0); vt.push_back(v);

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dut0_hc", int'(d0_hc), 0);
    chk("reset_dut0_syncs", int'({d0_hs, d0_vs}), 0);
    chk("reset_dut1_syncs", int'({d1_hs, d1_vs}), 3);
    chk("reset_dut0_strobes", int'({d0_bl, d0_de, d0_ls, d0_fs}), 7);
    reset = 1'b0;
    phase = 1'b1;
    @(negedge clk);
    chk("first_after_reset_hc", int'(d0_hc), 1);
    chk("first_after_reset_vc", int'(d0_vc), 0);
    repeat (2200) @(negedge clk);
    phase = 1'b0;

    chk("dut0_row0_hsync_width", hs0_cnt, 128);
    chk("dut0_row0_hsync_first", hs0_first, 840);
    chk("dut0_row0_blank_cycles", bl0_cnt, 256);
    chk("dut1_row0_hsync_low_width", hs1_cnt, 96);
    chk("dut1_row0_hsync_first", hs1_first, 656);
    chk("dut0_line_period", ls0_t1 - ls0_t0, 1056);
    chk("dut2_frame_period", fs2_t1 - fs2_t0, 66);
    chk("dut2_vsync_low_per_frame", vs2_cnt, 11);

    // Reset the tiny mode while its vsync is active.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mh[2] == 5 && mv[2] == 4) found = 1'b1;
      else @(negedge clk);
    end
    chk("wait_tiny_pos_5_4", int'(found), 1);
    if (found) chk("tiny_vsync_active_before_reset", int'(d2_vs), 0);

    foreach (vt[i]) begin
      reset = vt[i].rst;
      @(negedge clk);
      chk_obs($sformatf("tiny_vec%0d", i),
              mk(int'(d2_hc), int'(d2_vc), d2_hs, d2_vs, d2_bl, d2_ls, d2_fs), vt[i].e);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
